// File: rtl/arith_pkg.sv
// ----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic cells.
//   state_t       : sequencing states of the serial engines (IDLE/SHIFT/DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : width of a bit counter that has to reach WIDTH-1
// ----------------------------------------------------------------------------
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Floor of one bit so the counter stays legal for the smallest widths.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit a - b - bin, built like the full adder: two half subtractors in
// series with their borrows ORed.
//   a, b : operand bits
//   bin  : incoming borrow
//   diff : a ^ b ^ bin
//   bout : (~a & b) | (~(a ^ b) & bin)
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .diff (d1),
        .bout (b1)
    );

    // Second stage subtracts the incoming borrow from the partial difference;
    // its borrow is ~(a ^ b) & bin.
    half_subtractor u_hs1 (
        .a    (d1),
        .b    (bin),
        .diff (diff),
        .bout (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// ----------------------------------------------------------------------------
// half_subtractor
// One-bit a - b without an incoming borrow.
//   a, b : operand bits
//   diff : a ^ b
//   bout : borrow generated when a=0 and b=1
// ----------------------------------------------------------------------------
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial a - b, LSB first, one bit per clock through a single
// full_subtractor with a registered borrow.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   start      : request; operands captured when not busy (IDLE or DONE)
//   a, b       : minuend / subtrahend
//   busy       : high during the WIDTH shift cycles
//   done       : one-cycle pulse when diff/borrow_out carry a new result
//   diff       : (a - b) mod 2^WIDTH, held until the next result or reset
//   borrow_out : 1 iff a < b (unsigned), held alongside diff
// ----------------------------------------------------------------------------
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic           bff;
    logic           load;
    logic           shift_en;
    logic           last;
    logic           fs_d;
    logic           fs_bout;

    full_subtractor u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (bff),
        .diff (fs_d),
        .bout (fs_bout)
    );

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift_en = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == LAST_CNT) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                // Back-to-back accept: a start seen in DONE loads immediately.
                if (start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        cnt <= '0;
        else if (load)     cnt <= '0;
        else if (shift_en) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
        end else if (load) begin
            sa <= a;
            sb <= b;
        end else if (shift_en) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
        end
    end

    // Difference bits enter at the MSB, so after WIDTH shifts bit 0 of the
    // result lines up with bit 0 of the operands.
    always_ff @(posedge clk) begin
        if (!rst_n)        res <= '0;
        else if (shift_en) res <= {fs_d, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)        bff <= 1'b0;
        else if (load)     bff <= 1'b0;
        else if (shift_en) bff <= fs_bout;
    end

    // Status outputs are registered copies of the upcoming state, so they
    // line up with the state they describe without any input-to-output path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == SHIFT);
            done <= (state_nx == DONE);
        end
    end

    // The result is captured on the final shift edge, i.e. exactly the values
    // the result register and borrow FF hold while in DONE. Nothing partial
    // ever reaches the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (last) begin
            diff       <= {fs_d, res[WIDTH-1:1]};
            borrow_out <= fs_bout;
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `a - b` one bit per clock, LSB first, with a registered borrow chain. It is the inverse-operation companion to the team's full-adder arithmetic cells. It trades latency for area in control paths that need occasional wide subtraction. A `full_subtractor` cell does the per-bit arithmetic, and a small FSM handles load, shift and completion handshake.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  synchronous, active-low reset
- `start`  input  1  request; operands are sampled when `start` is high and the block is not busy
- `a`  input  WIDTH  minuend
- `b`  input  WIDTH  subtrahend
- `busy`  output  1  high while a subtraction is in progress
- `done`  output  1  single-cycle pulse when the result is valid
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH; held stable until the next accepted `start`
- `borrow_out`  output  1  final borrow; 1 iff `a < b` unsigned; held alongside `diff`

## Operation
- Reset is synchronous: when `rst_n` is low at a rising edge, the next state is as follows.
  - FSM goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `borrow_out`=0.
  - Internal shift registers, borrow FF and bit counter are cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with `start`=1:
  - Load `a`→`sa` and `b`→`sb`.
  - Clear the borrow FF and the counter.
  - Next state SHIFT.
- SHIFT, per cycle:
  - The `full_subtractor` takes `sa[0]`, `sb[0]` and the borrow FF.
  - `d` = `sa[0]` ^ `sb[0]` ^ `bin`.
  - `bout` = (~`sa[0]` & `sb[0]`) | (~(`sa[0]` ^ `sb[0]`) & `bin`).
  - Shift `d` into the result register from the MSB end (shift right).
  - Shift `sa` and `sb` right by one.
  - borrow FF ← `bout`; counter increments.
  - After WIDTH SHIFT cycles (counter = WIDTH-1 on the last one), next state is DONE.
- DONE, for exactly one cycle:
  - `done`=1; `diff` and `borrow_out` are updated from the result register and borrow FF.
  - Next state IDLE, or SHIFT if `start`=1 (back-to-back accept, operands loaded as in IDLE).
- `start` in SHIFT is ignored; operands are not re-sampled.
- `a` and `b` may change freely after acceptance without affecting the result.
- `diff` and `borrow_out` only change on the DONE cycle, or on reset.

## Timing
- `start` accepted at edge T0.
  - `busy`=1 from after T0 through the last SHIFT cycle.
  - SHIFT occupies edges T1..T(WIDTH).
  - `done`=1, with `diff`/`borrow_out` valid, in the cycle after edge T(WIDTH).
- Latency from accepting edge to `done` high: WIDTH+1 cycles. Throughput: one operation per WIDTH+1 cycles.
- `busy` is 0 in DONE.
- `start` and `done` may coincide in the DONE cycle; the new operation is accepted.
- `rst_n` low in any state aborts the operation. Partial results are never presented and `done` does not fire.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `arith_pkg`:
  - FSM state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH constant.
  - Counter width = clog2(WIDTH).
- Sub-module `full_subtractor` (ports `a`, `b`, `bin`, `diff`, `bout`):
  - Built from two `half_subtractor` instances plus an OR on the two borrows, mirroring the full-adder construction.
- Top level `serial_subtractor`:
  - FSM, counter, operand shift registers, result shift register, borrow FF, output registers.
  - Single always block per register group; single clock domain.

## Test plan
- `a`=100, `b`=37, `start` for 1 cycle → `done` exactly 9 cycles after accept, `diff`=63, `borrow_out`=0, `busy` high 8 cycles.
- `a`=37, `b`=100 → `diff`=193, `borrow_out`=1. `a`=0, `b`=1 → `diff`=255, `borrow_out`=1. `a`=`b`=8'hA5 → `diff`=0, `borrow_out`=0.
- Accept `a`=200, `b`=50; pulse `start` with `a`=1, `b`=2 during SHIFT → ignored; result `diff`=150, `borrow_out`=0.
- Hold `start` high continuously with `a`=10, `b`=3, then `a`=3, `b`=10 → back-to-back `done` pulses every 9 cycles; results 7 with borrow 0, then 249 with borrow 1.
- Assert `rst_n`=0 at the 4th SHIFT cycle → next cycle `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, and no `done` pulse follows. A new `start` after reset completes normally.
- Random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=16 versus a reference model computing `(a-b) mod 2^W` and `a<b`.
